io_out_fifo: RTL
================

IO_OUT_FIFO -- requirements
Module: io_out_fifo

Interface
REQ-001 Parameter DEPTH, default 16: number of word entries; SHALL be a power of two, 2..256.
REQ-002 Parameter PTR_W, default 4: SHALL equal log2(DEPTH).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 push  in  1  core requests enqueue of push_data this cycle.
REQ-006 push_data  in  `WORD_W  word to enqueue.
REQ-007 flush  in  1  discard all queued words.
REQ-008 full  out  1  high when count == DEPTH.
REQ-009 empty  out  1  high when count == 0.
REQ-010 count  out  PTR_W+1  number of queued words, 0..DEPTH.
REQ-011 overflow  out  1  sticky; a push was dropped.
REQ-012 out_req  out  1  one-cycle request to the UART output stage.
REQ-013 out_data  out  `WORD_W  word offered with out_req.
REQ-014 out_busy  in  1  output stage not ready; out_req honoured only when low.

Function
REQ-015 Storage: DEPTH x `WORD_W register array; read pointer rd_ptr, write pointer wr_ptr, each PTR_W bits, wrapping DEPTH-1 -> 0 by natural overflow.
REQ-016 out_data SHALL equal mem[rd_ptr] combinationally (show-ahead); value undefined-but-stable when empty.
REQ-017 out_req SHALL be combinational: out_req = ~empty & ~out_busy & ~flush.
REQ-018 pop occurs in every cycle with out_req high; rd_ptr += 1 at that edge.
REQ-019 Output stage contract: it captures out_data in the cycle out_req and ~out_busy are both high and raises out_busy the next cycle; one word per out_req cycle, never duplicated.
REQ-020 push accepted iff ~flush and (count < DEPTH or pop in same cycle); accepted word written to mem[wr_ptr], wr_ptr += 1.
REQ-021 push when not accepted due to full SHALL be dropped, pointers unchanged, overflow set to 1 next edge.
REQ-022 count next = count + accepted_push - pop; simultaneous push+pop leaves count unchanged, including at count == DEPTH.
REQ-023 No fall-through: word pushed into empty FIFO at edge t SHALL first appear with out_req in cycle t+1 at earliest.
REQ-024 flush high: next edge rd_ptr = wr_ptr = 0, count = 0, overflow = 0; same-cycle push ignored (not counted as overflow), out_req forced 0.
REQ-025 full, empty, overflow SHALL be driven from registers or directly decoded from the registered count; no dependency on push in the same cycle.
REQ-026 FIFO order SHALL be strict: words leave in push order across pointer wrap-around.

Reset
REQ-027 rstn low at edge: rd_ptr = 0, wr_ptr = 0, count = 0, overflow = 0; hence empty = 1, full = 0, out_req = 0.
REQ-028 Reset mid-transfer SHALL discard queued words; array contents need not be cleared.
REQ-029 out_req SHALL be 0 in any cycle where rstn is low.

Verification
REQ-030 Basic: out_busy = 0, push 32'h0000_0041 one cycle -> out_req high next cycle with out_data 32'h41, count 1 -> 0, empty returns to 1.
REQ-031 Backpressure: out_busy = 1, push 3 words A,B,C -> no out_req, count 3; release out_busy -> out_req with A; model busy high 3 cycles after each capture -> A,B,C delivered in order, exactly once each.
REQ-032 Full/overflow: out_busy = 1, push 17 words (DEPTH 16) -> full after 16th, 17th dropped, overflow = 1, count 16; drain -> first 16 words in order.
REQ-033 Simultaneous: count 16, out_busy = 0 and push D same cycle -> pop accepted, D accepted, count stays 16, overflow stays 0, D emerges last.
REQ-034 Wrap: push/pop 40 words with random out_busy -> output sequence equals input sequence, count never exceeds 16.
REQ-035 Flush/reset: 5 words queued, assert flush with push -> next cycle count 0, empty 1, overflow 0, no out_req; repeat with rstn low instead -> same result.

Source files
------------

// File: rtl/io_out_fifo.sv
// Output word FIFO between the core and the UART output stage.
// Show-ahead read port; pop is the handshake cycle itself (out_req).
`ifndef WORD_W
`define WORD_W 32
`endif

module io_out_fifo #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               push,
   input  logic [`WORD_W-1:0] push_data,
   input  logic               flush,
   output logic               full,
   output logic               empty,
   output logic [PTR_W:0]     count,
   output logic               overflow,
   output logic               out_req,
   output logic [`WORD_W-1:0] out_data,
   input  logic               out_busy
);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [`WORD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W:0]     cnt;
   logic               ovf;
   logic               pop;
   logic               push_ok;
   logic               push_drop;

   // Status comes only from the registered count, never from this cycle's push.
   assign empty    = (cnt == '0);
   assign full     = (cnt == DEPTH_C);
   assign count    = cnt;
   assign overflow = ovf;

   assign out_req  = rstn & ~empty & ~out_busy & ~flush;
   assign out_data = mem[rd_ptr];
   assign pop      = out_req;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok   = push & ~flush & (~full | pop);
   assign push_drop = push & ~flush & full & ~pop;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   cnt <= cnt + (PTR_W+1)'(1);
            2'b01:   cnt <= cnt - (PTR_W+1)'(1);
            default: cnt <= cnt;
         endcase
         if (push_drop)
            ovf <= 1'b1;
      end
   end

   // Storage is not reset; queued words are discarded by the pointer reset.
   always_ff @(posedge clk) begin
      if (rstn && push_ok)
         mem[wr_ptr] <= push_data;
   end

endmodule
